alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- EX→MEM pipeline stage directly downstream of the ALU.
- Captures the ALU result and flags (y, zf, cf, of) plus pass-through control.
- Derives set-less-than results from the flags and detects signed-overflow traps.
- Presents everything to the MEM stage through a valid/ready handshake, backed by a 2-entry skid buffer so back-pressure never forces a combinational ready path into EX.

Parameters:
- WIDTH, 32, datapath width; must match the ALU's WIDTH.
- REG_W, 5, destination register index width.
- ALUOP_W, 3, ALU opcode width.
- SIGNAL_W, 14, width of the pass-through control bundle.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  kill all buffered entries (branch/exception redirect).
- in_valid  input  1  EX presents a valid instruction.
- in_ready  output  1  stage can accept; registered.
- alu_y  input  WIDTH  ALU result.
- alu_zf  input  1  ALU zero flag.
- alu_cf  input  1  ALU carry/borrow flag.
- alu_of  input  1  ALU signed-overflow flag.
- aluop  input  ALUOP_W  opcode the ALU executed.
- res_sel  input  2  result select: 0=y, 1=slt, 2=sltu, 3=zf.
- trap_ov_en  input  1  instruction traps on signed overflow (add/sub, not addu/subu).
- wb_reg  input  REG_W  destination register.
- ctrl  input  SIGNAL_W  control bundle, passed through unchanged.
- out_valid  output  1  entry available to MEM.
- out_ready  input  1  MEM accepts.
- out_result  output  WIDTH  selected result.
- out_zf  output  1  captured zero flag.
- out_wb_reg  output  REG_W  destination; forced 0 on trap.
- out_ctrl  output  SIGNAL_W  control bundle.
- out_ovf_trap  output  1  overflow trap raised for this entry.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, in_ready=1, out_result=0, out_zf=0, out_wb_reg=0, out_ctrl=0, out_ovf_trap=0, skid entry invalid.
- Accept when in_valid & in_ready; transfer when out_valid & out_ready.
- Result derivation, computed at capture:
  - sel0 → alu_y.
  - sel1 → {WIDTH-1 zeros, alu_y[WIDTH-1]^alu_of}.
  - sel2 → {WIDTH-1 zeros, alu_cf}.
  - sel3 → {WIDTH-1 zeros, alu_zf}.
- Trap = trap_ov_en & alu_of & (aluop==`ALU_ADD | aluop==`ALU_SUB), using the codebase's ALU opcode defines.
  - On trap: out_ovf_trap=1, out_result=0, out_wb_reg=0, ctrl still passed through.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- States: EMPTY (out invalid, skid invalid), ONE (out valid, skid invalid), FULL (both valid).
  - EMPTY: accept→ONE.
  - ONE:
    - accept & transfer → ONE, output reg reloaded with the new entry.
    - accept & no transfer → FULL, new entry into skid.
    - transfer only → EMPTY.
    - neither → ONE.
  - FULL: transfer → ONE, skid moves to the output reg. No accept is possible in FULL.
- in_ready is registered and equals (next state != FULL).
  - Asserted again the cycle after FULL drains.
- Output registers hold stable while out_valid & !out_ready.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
- flush=1: next state EMPTY and in_ready=1, regardless of in_valid, out_ready or trap. A same-cycle input is discarded.
- Reset takes priority over flush.
- Reset mid-transfer discards all entries.
- Inputs are sampled only on accept; they may change freely otherwise.

Optional Feature:
- Macro: ALU_RESULT_STAGE_STATS_EN.
- When defined, adds three 32-bit output counters, all cleared by reset, not cleared by flush, and wrapping modulo 2^32:
  - stat_xfer: count of transfers.
  - stat_stall: cycles with out_valid & !out_ready.
  - stat_trap: transfers with out_ovf_trap=1.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles, then in_valid=1, alu_y=0x0000_0005, res_sel=0, wb_reg=3, out_ready=1 → next cycle out_valid=1, out_result=5, out_wb_reg=3; in_ready stays 1.
- aluop=`ALU_SUB, alu_y=0xFFFF_FFFE, alu_of=0, alu_cf=1, res_sel=1 → out_result=1. Same entry with res_sel=2 → out_result=1. alu_y=0x8000_0000, alu_of=1, res_sel=1 → out_result=0.
- aluop=`ALU_ADD, alu_of=1, trap_ov_en=1, wb_reg=7 → out_ovf_trap=1, out_result=0, out_wb_reg=0. With trap_ov_en=0 → out_ovf_trap=0, out_wb_reg=7.
- out_ready=0 while sending entries A, B, C back-to-back:
  - A, B accepted; in_ready drops after B; C is held upstream.
  - Release out_ready: outputs A, B, C in order, no loss; out_* stable during the stall.
- FULL state, then flush=1 with in_valid=1 (entry D) → next cycle out_valid=0, in_ready=1, D never appears.
- rst_n=0 asserted while FULL with out_ready=0 → next cycle all outputs at reset values. With ALU_RESULT_STAGE_STATS_EN defined, counters read 0 after reset and stat_stall equals the number of stalled cycles beforehand.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// EX->MEM handshake bundle for alu_result_stage: EX-side capture inputs and MEM-side outputs.
// The stage uses the slave modport; the surrounding pipeline (or bench) uses master.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned SIGNAL_W = 14
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    alu_y;
  logic                alu_zf;
  logic                alu_cf;
  logic                alu_of;
  logic [ALUOP_W-1:0]  aluop;
  logic [1:0]          res_sel;
  logic                trap_ov_en;
  logic [REG_W-1:0]    wb_reg;
  logic [SIGNAL_W-1:0] ctrl;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_result;
  logic                out_zf;
  logic [REG_W-1:0]    out_wb_reg;
  logic [SIGNAL_W-1:0] out_ctrl;
  logic                out_ovf_trap;

  modport master (
    output in_valid, alu_y, alu_zf, alu_cf, alu_of, aluop, res_sel, trap_ov_en, wb_reg, ctrl,
    output out_ready,
    input  in_ready, out_valid, out_result, out_zf, out_wb_reg, out_ctrl, out_ovf_trap
  );

  modport slave (
    input  in_valid, alu_y, alu_zf, alu_cf, alu_of, aluop, res_sel, trap_ov_en, wb_reg, ctrl,
    input  out_ready,
    output in_ready, out_valid, out_result, out_zf, out_wb_reg, out_ctrl, out_ovf_trap
  );
endinterface

// File: rtl/alu_result_stage.sv
// EX->MEM result stage: SLT/SLTU/ZF result select, overflow trap, 2-entry skid buffer.
// Optional counters stat_xfer/stat_stall/stat_trap enabled by ALU_RESULT_STAGE_STATS_EN.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif

module alu_result_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned SIGNAL_W = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  alu_result_stage_if.slave bus
`ifdef ALU_RESULT_STAGE_STATS_EN
  ,
  output logic [31:0] stat_xfer,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_trap
`endif
);
  localparam int unsigned PW = WIDTH + 1 + REG_W + SIGNAL_W + 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_ready;
  logic [PW-1:0]    r_out;
  logic [PW-1:0]    r_skid;
  logic [PW-1:0]    w_capture;
  logic [WIDTH-1:0] w_sel_result;
  logic             w_accept;
  logic             w_xfer;
  logic             w_is_addsub;
  logic             w_trap;
  logic             w_load_out_new;
  logic             w_load_out_skid;
  logic             w_load_skid;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_xfer      = (r_state != EMPTY) & bus.out_ready;
  assign w_is_addsub = (bus.aluop == ALUOP_W'(`ALU_ADD)) | (bus.aluop == ALUOP_W'(`ALU_SUB));
  assign w_trap      = bus.trap_ov_en & bus.alu_of & w_is_addsub;

  always_comb begin
    w_sel_result = '0;
    case (bus.res_sel)
      2'd0:    w_sel_result = bus.alu_y;
      2'd1:    w_sel_result[0] = bus.alu_y[WIDTH-1] ^ bus.alu_of;
      2'd2:    w_sel_result[0] = bus.alu_cf;
      default: w_sel_result[0] = bus.alu_zf;
    endcase
  end

  // A trapping entry keeps its ctrl/zf but must not write back anything.
  assign w_capture = {w_trap ? {WIDTH{1'b0}} : w_sel_result,
                      bus.alu_zf,
                      w_trap ? {REG_W{1'b0}} : bus.wb_reg,
                      bus.ctrl,
                      w_trap};

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_new  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ONE;
          w_load_out_new = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_xfer) begin
          w_load_out_new = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_xfer) begin
          w_state_nxt     = ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt     = EMPTY;
      w_load_out_new  = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
      if (w_load_out_new) begin
        r_out <= w_capture;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_capture;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != EMPTY);
  assign {bus.out_result, bus.out_zf, bus.out_wb_reg, bus.out_ctrl, bus.out_ovf_trap} = r_out;

`ifdef ALU_RESULT_STAGE_STATS_EN
  logic [31:0] r_stat_xfer;
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_trap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_xfer  <= '0;
      r_stat_stall <= '0;
      r_stat_trap  <= '0;
    end else begin
      if (w_xfer) begin
        r_stat_xfer <= r_stat_xfer + 32'd1;
      end
      if ((r_state != EMPTY) && !bus.out_ready) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
      if (w_xfer && r_out[0]) begin
        r_stat_trap <= r_stat_trap + 32'd1;
      end
    end
  end

  assign stat_xfer  = r_stat_xfer;
  assign stat_stall = r_stat_stall;
  assign stat_trap  = r_stat_trap;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Table-driven scoreboard bench for alu_result_stage: result select, traps, skid/stall, flush, reset.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif

module tb_alu_result_stage;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SIGNAL_W = 14;
  localparam logic [2:0] OP_ADD = `ALU_ADD;
  localparam logic [2:0] OP_SUB = `ALU_SUB;
  localparam logic [2:0] OP_AND = 3'd2;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] y;
    logic        zf, cf, of;
    logic [1:0]  sel;
    logic        ten;
    logic [4:0]  wb;
    logic [13:0] ctrl;
    logic [31:0] e_res;
    logic        e_zf;
    logic [4:0]  e_wb;
    logic        e_trap;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        zf;
    logic [4:0]  wb;
    logic [13:0] ctrl;
    logic        trap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(WIDTH), .REG_W(REG_W), .ALUOP_W(ALUOP_W), .SIGNAL_W(SIGNAL_W)) bus ();

`ifdef ALU_RESULT_STAGE_STATS_EN
  logic [31:0] stat_xfer, stat_stall, stat_trap;
`endif

  alu_result_stage #(.WIDTH(WIDTH), .REG_W(REG_W), .ALUOP_W(ALUOP_W), .SIGNAL_W(SIGNAL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
`ifdef ALU_RESULT_STAGE_STATS_EN
    ,
    .stat_xfer  (stat_xfer),
    .stat_stall (stat_stall),
    .stat_trap  (stat_trap)
`endif
  );

  vec_t  tv [12];
  exp_t  q [$];
  exp_t  cur_exp;
  logic  last_acc;
  logic  rand_ready = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    tb_xfer = 0, tb_stall = 0, tb_trap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: check/score at the negedge, then step past the posedge.
  task automatic tick();
    last_acc = 1'b0;
    @(negedge clk);
    if (rst_n) begin
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %0h, expected no valid entry", bus.out_result);
        end else begin
          chk("scoreboard", {bus.out_result, bus.out_zf, bus.out_wb_reg, bus.out_ctrl, bus.out_ovf_trap}, q[0]);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) tb_stall++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && q.size() > 0) begin
        tb_xfer++;
        if (q[0].trap) tb_trap++;
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        q.push_back(cur_exp);
        last_acc = 1'b1;
      end
    end else begin
      q.delete();
      tb_xfer = 0;
      tb_stall = 0;
      tb_trap = 0;
    end
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input int i);
    bus.aluop      = tv[i].op;
    bus.alu_y      = tv[i].y;
    bus.alu_zf     = tv[i].zf;
    bus.alu_cf     = tv[i].cf;
    bus.alu_of     = tv[i].of;
    bus.res_sel    = tv[i].sel;
    bus.trap_ov_en = tv[i].ten;
    bus.wb_reg     = tv[i].wb;
    bus.ctrl       = tv[i].ctrl;
    cur_exp        = '{tv[i].e_res, tv[i].e_zf, tv[i].e_wb, tv[i].ctrl, tv[i].e_trap};
    bus.in_valid   = 1'b1;
  endtask

  task automatic send(input int i, input int max_cycles);
    int n = 0;
    drive(i);
    do begin
      tick();
      n++;
    end while (!last_acc && n < max_cycles);
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: vector %0d not accepted within %0d cycles", i, max_cycles);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    rand_ready = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
    chk({tag, "_payload"},   64'({bus.out_result, bus.out_zf, bus.out_wb_reg, bus.out_ctrl, bus.out_ovf_trap}), 64'd0);
  endtask

  initial begin
    int n;
    //           op      y             zf cf of sel ten wb     ctrl      e_res         e_zf e_wb  e_trap
    tv[0]  = '{OP_ADD, 32'h0000_0005, 0, 0, 0, 2'd0, 0, 5'd3,  14'h0011, 32'h0000_0005, 0, 5'd3,  0};
    tv[1]  = '{OP_SUB, 32'hFFFF_FFFE, 0, 1, 0, 2'd1, 0, 5'd4,  14'h0102, 32'h0000_0001, 0, 5'd4,  0};
    tv[2]  = '{OP_SUB, 32'hFFFF_FFFE, 0, 1, 0, 2'd2, 0, 5'd4,  14'h0203, 32'h0000_0001, 0, 5'd4,  0};
    tv[3]  = '{OP_SUB, 32'h8000_0000, 0, 0, 1, 2'd1, 0, 5'd5,  14'h0304, 32'h0000_0000, 0, 5'd5,  0};
    tv[4]  = '{OP_ADD, 32'h8000_0001, 0, 1, 1, 2'd0, 1, 5'd7,  14'h2AAA, 32'h0000_0000, 0, 5'd0,  1};
    tv[5]  = '{OP_ADD, 32'h8000_0001, 0, 1, 1, 2'd0, 0, 5'd7,  14'h1555, 32'h8000_0001, 0, 5'd7,  0};
    tv[6]  = '{OP_AND, 32'h0000_0F0F, 0, 0, 1, 2'd0, 1, 5'd9,  14'h0606, 32'h0000_0F0F, 0, 5'd9,  0};
    tv[7]  = '{OP_AND, 32'h0000_0000, 1, 0, 0, 2'd3, 0, 5'd10, 14'h0707, 32'h0000_0001, 1, 5'd10, 0};
    tv[8]  = '{OP_SUB, 32'h7FFF_FFFF, 1, 1, 1, 2'd1, 1, 5'd11, 14'h3FFF, 32'h0000_0000, 1, 5'd0,  1};
    tv[9]  = '{OP_AND, 32'h0000_1234, 0, 0, 0, 2'd3, 0, 5'd12, 14'h0909, 32'h0000_0000, 0, 5'd12, 0};
    tv[10] = '{OP_ADD, 32'h0000_0001, 0, 0, 1, 2'd1, 0, 5'd13, 14'h0A0A, 32'h0000_0001, 0, 5'd13, 0};
    tv[11] = '{OP_SUB, 32'hFFFF_FFFF, 0, 0, 0, 2'd2, 0, 5'd31, 14'h0B0B, 32'h0000_0000, 0, 5'd31, 0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_y = '0; bus.alu_zf = 1'b0;
    bus.alu_cf = 1'b0; bus.alu_of = 1'b0; bus.aluop = '0; bus.res_sel = '0;
    bus.trap_ov_en = 1'b0; bus.wb_reg = '0; bus.ctrl = '0;
    cur_exp = '0;

    // Reset held two cycles
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // First entry: one-cycle latency, in_ready stays high
    bus.out_ready = 1'b1;
    drive(0);
    tick();
    chk("first_accept", 64'(last_acc), 64'd1);
    chk("first_latency_valid", 64'(bus.out_valid), 64'd1);
    chk("first_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("first_drained", 64'(q.size()), 64'd0);

    // Whole table streamed back-to-back, then with random back-pressure
    for (int i = 0; i < 12; i++) send(i, 4);
    drain(20);
    rand_ready = 1'b1;
    for (int i = 11; i >= 0; i--) send(i, 20);
    drain(20);

    // A, B, C against a stalled MEM: C held until FULL drains
    bus.out_ready = 1'b0;
    drive(0); tick(); chk("abc_a_accept", 64'(last_acc), 64'd1);
    drive(4); tick(); chk("abc_b_accept", 64'(last_acc), 64'd1);
    chk("abc_in_ready_full", 64'(bus.in_ready), 64'd0);
    drive(8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abc_c_held", 64'(last_acc), 64'd0);
      chk("abc_in_ready_stall", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 10);
    chk("abc_c_accept_cycle", 64'(n), 64'd2);
    drain(10);

    // Flush from FULL with a new entry offered
    bus.out_ready = 1'b0;
    send(1, 4);
    send(2, 4);
    drive(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_full_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_full_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Flush from ONE: the accepted-looking same-cycle input is discarded
    bus.out_ready = 1'b0;
    send(5, 4);
    drive(6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_one_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_one_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) tick();

`ifdef ALU_RESULT_STAGE_STATS_EN
    chk("stat_xfer", 64'(stat_xfer), 64'(tb_xfer));
    chk("stat_trap", 64'(stat_trap), 64'(tb_trap));
`endif

    // Reset while FULL and stalled
    bus.out_ready = 1'b0;
    send(7, 4);
    send(9, 4);
    repeat (3) tick();
`ifdef ALU_RESULT_STAGE_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'(tb_stall));
`endif
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("midreset");
`ifdef ALU_RESULT_STAGE_STATS_EN
    chk("stat_cleared", 64'({stat_xfer, stat_stall}) | 64'(stat_trap), 64'd0);
`endif
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    send(10, 4);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
